// File: rtl/demux_router_if.sv
// Bus bundle for demux_router: one input stream, N_CH output streams,
// and the routing/status sideband.
// slave  : router side (drives in_ready, outputs, status)
// master : source/sink side (drives in_*, sel, mode, out_ready)
interface demux_router_if #(
    parameter int WIDTH = 8,
    parameter int N_CH  = 4,
    parameter int SEL_W = 2
) ();
    logic [WIDTH-1:0]      in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic [SEL_W-1:0]      sel;
    logic                  mode;
    logic [N_CH*WIDTH-1:0] out_data;
    logic [N_CH-1:0]       out_valid;
    logic [N_CH-1:0]       out_ready;
    logic [SEL_W-1:0]      cur_ch;
    logic                  sel_err;
    logic [N_CH*16-1:0]    beat_cnt;

    modport slave (
        input  in_data, in_valid, sel, mode, out_ready,
        output in_ready, out_data, out_valid, cur_ch, sel_err, beat_cnt
    );

    modport master (
        output in_data, in_valid, sel, mode, out_ready,
        input  in_ready, out_data, out_valid, cur_ch, sel_err, beat_cnt
    );
endinterface

// File: rtl/demux_router.sv
// demux_router: routes a valid/ready input stream to one of N_CH one-entry
// output registers, chosen either by an explicit select or by a round-robin
// pointer. Optional per-channel accepted-beat counters are built only when
// the macro DEMUX_ROUTER_CNT_EN is defined; otherwise beat_cnt is tied to 0.
module demux_router #(
    parameter int WIDTH = 8,
    parameter int N_CH  = 4,
    parameter int SEL_W = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    demux_router_if.slave    bus
);

    // Select space rounded up to a power of two so that an out-of-range
    // select can index the padded vectors without reading past the end.
    localparam int         N_PAD  = 1 << SEL_W;
    localparam logic [SEL_W:0] NCH_V = (SEL_W+1)'(N_CH);
    localparam logic [SEL_W-1:0] RR_LAST = SEL_W'(N_CH - 1);

    logic [N_CH-1:0]             valid_q, valid_d;
    logic [N_CH-1:0][WIDTH-1:0]  data_q,  data_d;
    logic [SEL_W-1:0]            rr_q,    rr_d;

    logic [SEL_W-1:0]            tgt;
    logic                        sel_err;
    logic                        in_ready;
    logic                        xfer;
    logic [N_PAD-1:0]            vld_pad;
    logic [N_PAD-1:0]            rdy_pad;
    logic [N_CH-1:0]             load_vec;

    // Target selection, select check and input handshake.
    always_comb begin
        tgt      = bus.mode ? rr_q : bus.sel;
        sel_err  = !bus.mode && ({1'b0, bus.sel} >= NCH_V);
        vld_pad  = '0;
        rdy_pad  = '0;
        vld_pad[N_CH-1:0] = valid_q;
        rdy_pad[N_CH-1:0] = bus.out_ready;
        in_ready = !sel_err && (!vld_pad[tgt] || rdy_pad[tgt]);
        xfer     = bus.in_valid && in_ready;
    end

    // Per-channel next state: a load wins over a drain, so a channel that
    // drains and loads in the same cycle stays valid with the new beat.
    always_comb begin
        load_vec = '0;
        valid_d  = valid_q;
        data_d   = data_q;
        for (int k = 0; k < N_CH; k++) begin
            load_vec[k] = xfer && (tgt == SEL_W'(k));
            if (load_vec[k]) begin
                valid_d[k] = 1'b1;
                data_d[k]  = bus.in_data;
            end else if (valid_q[k] && bus.out_ready[k]) begin
                valid_d[k] = 1'b0;
            end
        end
    end

    // Round-robin pointer moves only on an accepted beat in auto mode.
    always_comb begin
        rr_d = rr_q;
        if (xfer && bus.mode) begin
            rr_d = (rr_q == RR_LAST) ? '0 : rr_q + SEL_W'(1);
        end
    end

    // State registers; reset overrides any same-cycle transfer or drain.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= '0;
            data_q  <= '0;
            rr_q    <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            rr_q    <= rr_d;
        end
    end

`ifdef DEMUX_ROUTER_CNT_EN
    logic [N_CH-1:0][15:0] cnt_q, cnt_d;

    // Accepted-beat counters, free-running wrap at 16 bits.
    always_comb begin
        cnt_d = cnt_q;
        for (int k = 0; k < N_CH; k++) begin
            if (load_vec[k]) begin
                cnt_d[k] = cnt_q[k] + 16'd1;
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bus.beat_cnt = cnt_q;
`else
    assign bus.beat_cnt = '0;
`endif

    assign bus.in_ready  = in_ready;
    assign bus.sel_err   = sel_err;
    assign bus.cur_ch    = tgt;
    assign bus.out_valid = valid_q;
    assign bus.out_data  = data_q;

endmodule

// File: tb/tb_demux_router.sv
// Directed bench for demux_router: a default 4-channel instance and a
// 3-channel instance for the out-of-range select case.
module tb_demux_router;

`ifdef DEMUX_ROUTER_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    demux_router_if #(.WIDTH(8), .N_CH(4), .SEL_W(2)) if4 ();
    demux_router_if #(.WIDTH(8), .N_CH(3), .SEL_W(2)) if3 ();

    demux_router #(.WIDTH(8), .N_CH(4), .SEL_W(2)) u_dut4 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (if4)
    );

    demux_router #(.WIDTH(8), .N_CH(3), .SEL_W(2)) u_dut3 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (if3)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        int n1;
        if4.in_data = '0; if4.in_valid = 1'b0; if4.sel = '0; if4.mode = 1'b1; if4.out_ready = '0;
        if3.in_data = '0; if3.in_valid = 1'b0; if3.sel = '0; if3.mode = 1'b0; if3.out_ready = '0;

        // Reset
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        #1;
        chk("rst_out_valid", 64'(if4.out_valid), 64'h0);
        chk("rst_out_data",  64'(if4.out_data),  64'h0);
        chk("rst_beat_cnt",  64'(if4.beat_cnt),  64'h0);
        chk("rst_rr",        64'(if4.cur_ch),    64'h0);
        chk("rst_in_ready",  64'(if4.in_ready),  64'h1);

        // Scenario 1: explicit select
        if4.mode = 1'b0; if4.out_ready = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            if4.sel = 2'(i); if4.in_data = 8'hA0 + 8'(i); if4.in_valid = 1'b1;
            #1;
            chk("s1_in_ready", 64'(if4.in_ready), 64'h1);
            chk("s1_cur_ch",   64'(if4.cur_ch),   64'(i));
            tick();
            chk("s1_out_valid", 64'(if4.out_valid), 64'(1 << i));
            chk("s1_out_data",  64'(if4.out_data[i*8 +: 8]), 64'(8'hA0 + 8'(i)));
        end
        if4.in_valid = 1'b0;
        tick();
        chk("s1_idle_valid", 64'(if4.out_valid), 64'h0);
        chk("s1_hold_data",  64'(if4.out_data), 64'hA3A2A1A0);
        chk("s1_cnt", 64'(if4.beat_cnt), CNT_EN ? 64'h0001_0001_0001_0001 : 64'h0);

        // Scenario 2: round-robin with wrap
        if4.mode = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if4.in_data = 8'hB0 + 8'(i); if4.in_valid = 1'b1;
            #1;
            chk("s2_cur_ch", 64'(if4.cur_ch), 64'(i % 4));
            tick();
            chk("s2_out_valid", 64'(if4.out_valid), 64'(1 << (i % 4)));
            chk("s2_out_data",  64'(if4.out_data[(i % 4)*8 +: 8]), 64'(8'hB0 + 8'(i)));
        end
        if4.in_valid = 1'b0;
        tick();
        chk("s2_rr_after", 64'(if4.cur_ch), 64'h2);
        chk("s2_no_load",  64'(if4.out_valid), 64'h0);
        if4.mode = 1'b0; if4.sel = 2'd1;
        #1;
        chk("s2_mode_sw_sel", 64'(if4.cur_ch), 64'h1);
        if4.mode = 1'b1;
        #1;
        chk("s2_rr_retained", 64'(if4.cur_ch), 64'h2);
        chk("s2_cnt", 64'(if4.beat_cnt), CNT_EN ? 64'h0002_0002_0003_0003 : 64'h0);

        // Scenario 3: backpressure on channel 2
        tick();
        if4.mode = 1'b0; if4.sel = 2'd2; if4.out_ready = 4'b1011;
        if4.in_data = 8'hC0; if4.in_valid = 1'b1;
        #1;
        chk("s3_first_ready", 64'(if4.in_ready), 64'h1);
        tick();
        chk("s3_first_valid", 64'(if4.out_valid), 64'h4);
        if4.in_data = 8'hC1;
        #1;
        chk("s3_blocked", 64'(if4.in_ready), 64'h0);
        tick();
        chk("s3_held_valid", 64'(if4.out_valid), 64'h4);
        chk("s3_held_data",  64'(if4.out_data[23:16]), 64'hC0);
        if4.out_ready = 4'b1111;
        #1;
        chk("s3_unblocked", 64'(if4.in_ready), 64'h1);
        tick();
        chk("s3_no_bubble", 64'(if4.out_valid), 64'h4);
        chk("s3_second_data", 64'(if4.out_data[23:16]), 64'hC1);
        if4.in_valid = 1'b0;
        tick();
        chk("s3_drained", 64'(if4.out_valid), 64'h0);
        chk("s3_cnt", 64'(if4.beat_cnt), CNT_EN ? 64'h0002_0004_0003_0003 : 64'h0);

        // Scenario 4: invalid select on the 3-channel instance
        if3.mode = 1'b0; if3.sel = 2'd3; if3.in_data = 8'h5A; if3.in_valid = 1'b1; if3.out_ready = 3'b000;
        #1;
        chk("s4_sel_err",  64'(if3.sel_err),  64'h1);
        chk("s4_in_ready", 64'(if3.in_ready), 64'h0);
        tick();
        chk("s4_no_load", 64'(if3.out_valid), 64'h0);
        if3.sel = 2'd2;
        #1;
        chk("s4_sel_ok",   64'(if3.sel_err),  64'h0);
        chk("s4_ready_ok", 64'(if3.in_ready), 64'h1);
        tick();
        chk("s4_load2", 64'(if3.out_valid), 64'h4);
        chk("s4_data2", 64'(if3.out_data[23:16]), 64'h5A);
        if3.mode = 1'b1; if3.sel = 2'd3; if3.out_ready = 3'b111;
        for (int i = 0; i < 3; i++) begin
            if3.in_data = 8'h60 + 8'(i);
            #1;
            chk("s4_rr_sel_err", 64'(if3.sel_err), 64'h0);
            chk("s4_rr_cur",     64'(if3.cur_ch),  64'(i));
            tick();
        end
        if3.in_valid = 1'b0;
        #1;
        chk("s4_rr_wrap", 64'(if3.cur_ch), 64'h0);
        chk("s4_rr_data", 64'(if3.out_data), 64'h626160);

        // Scenario 5: reset mid-operation with full channels
        if4.mode = 1'b1; if4.out_ready = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            if4.in_data = 8'hD0 + 8'(i); if4.in_valid = 1'b1;
            tick();
        end
        chk("s5_full", 64'(if4.out_valid), 64'hF);
        chk("s5_data", 64'(if4.out_data), 64'hD1D0D3D2);
        chk("s5_cnt",  64'(if4.beat_cnt), CNT_EN ? 64'h0003_0005_0004_0004 : 64'h0);
        if4.in_data = 8'hD4;
        #1;
        chk("s5_full_ready", 64'(if4.in_ready), 64'h0);
        if4.out_ready = 4'b1111;
        rst = 1'b1;
        tick();
        rst = 1'b0; if4.in_valid = 1'b0;
        #1;
        chk("s5_rst_valid", 64'(if4.out_valid), 64'h0);
        chk("s5_rst_data",  64'(if4.out_data),  64'h0);
        chk("s5_rst_rr",    64'(if4.cur_ch),    64'h0);
        chk("s5_rst_cnt",   64'(if4.beat_cnt),  64'h0);
        chk("s5_rst_ready", 64'(if4.in_ready),  64'h1);

        // Scenario 6: counter wrap on channel 1
        n1 = CNT_EN ? 65535 : 12;
        tick();
        if4.mode = 1'b0; if4.sel = 2'd1; if4.out_ready = 4'b1111;
        if4.in_data = 8'hE1; if4.in_valid = 1'b1;
        repeat (n1) @(posedge clk);
        #1;
        chk("s6_cnt_ffff", 64'(if4.beat_cnt), CNT_EN ? 64'h0000_0000_FFFF_0000 : 64'h0);
        chk("s6_stream_valid", 64'(if4.out_valid), 64'h2);
        @(posedge clk);
        #1;
        chk("s6_cnt_wrap", 64'(if4.beat_cnt), 64'h0);
        @(posedge clk);
        #1;
        if4.in_valid = 1'b0;
        chk("s6_cnt_one", 64'(if4.beat_cnt), CNT_EN ? 64'h0000_0000_0001_0000 : 64'h0);
        tick(); tick();
        chk("s6_idle_valid", 64'(if4.out_valid), 64'h0);
        chk("s6_idle_cnt", 64'(if4.beat_cnt), CNT_EN ? 64'h0000_0000_0001_0000 : 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
